// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU issue stage: op codes, FSM states, request word.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package alu4_pkg;

    // ALU function codes as seen on alu_c / out_op
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // Issue-stage FSM states
    //   ST_IDLE  : FIFO empty and no result pending
    //   ST_RUN   : work queued, output register free or draining
    //   ST_STALL : work queued, result held by downstream backpressure
    //   ST_DRAIN : FIFO empty, last result waiting to be taken
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // One queued ALU request
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic       cin;
    } req_t;

    // Carry-in actually presented to the ALU: subtract/compare ops need a
    // forced 1 (two's-complement of b), logic ops want 0, ADD passes the request's cin.
    function automatic logic op_cin(input logic [2:0] op, input logic cin);
        logic r;
        case (op)
            OP_ADD:              r = cin;
            OP_SUB, OP_LT, OP_EQ: r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

    // Bitwise ops: carry and overflow are meaningless and get cleared
    function automatic logic op_is_logic(input logic [2:0] op);
        return (op == OP_NOT) || (op == OP_AND) || (op == OP_OR) || (op == OP_XOR);
    endfunction

    // Compare ops: the only ones whose size flag is kept
    function automatic logic op_is_cmp(input logic [2:0] op);
        return (op == OP_LT) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/alu4_req_fifo.sv
// In-order request FIFO of DEPTH entries with combinational head read.
// Latency: a pushed entry is visible at o_head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; o_full drives upstream ready.
module alu4_req_fifo
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  req_t                     i_dat,
    input  logic                     i_pop,
    output req_t                     o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    // DEPTH is a power of two, so pointers wrap for free at PW bits
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    req_t          r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_dat;
    end

endmodule

// File: rtl/alu4_issue.sv
// Queues 4-bit ALU requests, drives an external combinational ALU and registers its masked flags.
// Latency: request accepted into an empty idle block shows out_valid two edges later; 1 result/cycle sustained.
// Backpressure: out_ready low holds the result register and stops issue; in_ready drops only when the FIFO is full.
module alu4_issue
    import alu4_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clk,
    input  logic                     rst,
    // request side
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic [2:0]               in_op,
    input  logic                     in_cin,
    // downstream ALU drive
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_c,
    output logic                     alu_cin,
    // downstream ALU results (combinational from alu_*)
    input  logic [3:0]               alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_overflow,
    input  logic                     alu_carry,
    input  logic                     alu_size,
    // result side
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_result,
    output logic                     out_zero,
    output logic                     out_overflow,
    output logic                     out_carry,
    output logic                     out_size,
    output logic [2:0]               out_op,
    // status
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = DEPTH[PW:0];

    // FIFO interface
    req_t        w_in_req;
    req_t        w_head;
    logic [PW:0] w_count;
    logic        w_full;
    logic        w_empty;
    logic        w_push;

    // issue control
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_can_out;
    logic        w_issue;
    logic        w_head_cin;
    logic [PW:0] w_cnt_next;
    logic        w_ov_next;

    // last values presented to the ALU
    logic [3:0]  r_alu_a;
    logic [3:0]  r_alu_b;
    logic [2:0]  r_alu_c;
    logic        r_alu_cin;

    // captured result
    logic        r_out_valid;
    logic [3:0]  r_out_result;
    logic        r_out_zero;
    logic        r_out_overflow;
    logic        r_out_carry;
    logic        r_out_size;
    logic [2:0]  r_out_op;

    // The ALU's own zero flag is not used: zero is recomputed from the
    // captured result so it always agrees with out_result.
    logic        w_unused_alu_zero;
    assign w_unused_alu_zero = alu_zero;

    assign w_in_req = '{a: in_a, b: in_b, op: in_op, cin: in_cin};

    // Ready looks only at occupancy; a pop in the same cycle does not open a slot early
    assign in_ready = (w_count != CNT_FULL);
    assign w_push   = in_valid && in_ready;

    alu4_req_fifo #(
        .DEPTH   (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   (w_in_req),
        .i_pop   (w_issue),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Issue when there is work and the result register is free or being emptied.
    // IDLE never issues: the first request after idle spends one cycle waking the FSM,
    // which gives the two-edge latency from an idle block.
    assign w_can_out  = !r_out_valid || out_ready;
    assign w_issue    = (r_state != ST_IDLE) && !w_empty && w_can_out;
    assign w_head_cin = op_cin(w_head.op, w_head.cin);

    // ALU inputs follow the FIFO head while issuing, otherwise hold the last issue
    assign alu_a   = w_issue ? w_head.a   : r_alu_a;
    assign alu_b   = w_issue ? w_head.b   : r_alu_b;
    assign alu_c   = w_issue ? w_head.op  : r_alu_c;
    assign alu_cin = w_issue ? w_head_cin : r_alu_cin;

    // Occupancy and output-valid as they will be after this edge, for the FSM
    always_comb begin
        w_cnt_next = w_count;
        case ({w_push, w_issue})
            2'b10:   w_cnt_next = w_count + 1'b1;
            2'b01:   w_cnt_next = w_count - 1'b1;
            default: w_cnt_next = w_count;
        endcase
        w_ov_next = w_issue || (r_out_valid && !out_ready);
    end

    // Next-state: IDLE wakes on a non-empty FIFO; otherwise classify the coming cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_state_nxt = ST_RUN;
            end
            default: begin
                if (w_cnt_next != '0) begin
                    if (!w_issue && r_out_valid && !out_ready) w_state_nxt = ST_STALL;
                    else                                        w_state_nxt = ST_RUN;
                end else if (w_ov_next) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Remember what was last presented to the ALU so the drive is stable between issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_c   <= '0;
            r_alu_cin <= 1'b0;
        end else if (w_issue) begin
            r_alu_a   <= w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_c   <= w_head.op;
            r_alu_cin <= w_head_cin;
        end
    end

    // Capture ALU result with per-op flag masking; clear valid when taken without a refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_zero     <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_carry    <= 1'b0;
            r_out_size     <= 1'b0;
            r_out_op       <= '0;
        end else if (w_issue) begin
            r_out_valid    <= 1'b1;
            r_out_result   <= alu_result;
            r_out_zero     <= (alu_result == 4'd0);
            r_out_overflow <= op_is_logic(w_head.op) ? 1'b0 : alu_overflow;
            r_out_carry    <= op_is_logic(w_head.op) ? 1'b0 : alu_carry;
            r_out_size     <= op_is_cmp(w_head.op)   ? alu_size : 1'b0;
            r_out_op       <= w_head.op;
        end else if (r_out_valid && out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_zero     = r_out_zero;
    assign out_overflow = r_out_overflow;
    assign out_carry    = r_out_carry;
    assign out_size     = r_out_size;
    assign out_op       = r_out_op;

    assign busy  = !w_empty || r_out_valid;
    assign count = w_count;

endmodule
